// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus bundling imem handshake, hazard/redirect inputs and IF/ID outputs.
interface fetch_stage_if #(parameter int DATA_W = 32);
    logic              in_stall;
    logic              in_redirect;
    logic [31:0]       in_redirect_pc;
    logic              out_imem_req;
    logic [31:0]       out_imem_addr;
    logic              in_imem_ack;
    logic [DATA_W-1:0] in_imem_data;
    logic              out_valid;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_instr;
    logic [3:0]        out_opcode;
    modport master (
        input  in_stall, in_redirect, in_redirect_pc, in_imem_ack, in_imem_data,
        output out_imem_req, out_imem_addr, out_valid, out_pc, out_instr, out_opcode
    );
    modport slave (
        output in_stall, in_redirect, in_redirect_pc, in_imem_ack, in_imem_data,
        input  out_imem_req, out_imem_addr, out_valid, out_pc, out_instr, out_opcode
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem request, one-word skid buffer and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
) (
    input logic          in_clk,
    input logic          in_rst,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_DROP, S_FULL} state_t;
    state_t            r_state, w_state_nx;
    logic [31:0]       r_pc, w_pc_nx, r_stale, w_stale_nx, r_skid_pc, w_skid_pc_nx;
    logic [DATA_W-1:0] r_skid_data, w_skid_data_nx;
    logic              r_valid;
    logic [31:0]       r_out_pc;
    logic [DATA_W-1:0] r_instr;
    logic              w_req, w_ack, w_load;
    logic [31:0]       w_ld_pc;
    logic [DATA_W-1:0] w_ld_data;
    always_comb begin
        w_req          = !in_rst && r_state != S_FULL;
        w_ack          = w_req && bus.in_imem_ack;
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_stale_nx     = r_stale;
        w_skid_pc_nx   = r_skid_pc;
        w_skid_data_nx = r_skid_data;
        w_load         = 1'b0;
        w_ld_pc        = r_pc;
        w_ld_data      = bus.in_imem_data;
        case (r_state)
            S_REQ: begin
                if (w_ack) begin
                    w_pc_nx = bus.in_redirect ? bus.in_redirect_pc : r_pc + 32'd1;
                    w_load  = !bus.in_redirect && !bus.in_stall;
                    if (!bus.in_redirect && bus.in_stall) begin
                        w_skid_pc_nx   = r_pc;
                        w_skid_data_nx = bus.in_imem_data;
                        w_state_nx     = S_FULL;
                    end
                end else if (bus.in_redirect) begin
                    // the in-flight address must stay on the bus until its ack arrives
                    w_stale_nx = r_pc;
                    w_pc_nx    = bus.in_redirect_pc;
                    w_state_nx = S_DROP;
                end
            end
            S_DROP: begin
                w_pc_nx    = bus.in_redirect ? bus.in_redirect_pc : r_pc;
                w_state_nx = w_ack ? S_REQ : S_DROP;
            end
            S_FULL: begin
                if (bus.in_redirect) begin
                    w_pc_nx    = bus.in_redirect_pc;
                    w_state_nx = S_REQ;
                end else if (!bus.in_stall) begin
                    w_load     = 1'b1;
                    w_ld_pc    = r_skid_pc;
                    w_ld_data  = r_skid_data;
                    w_state_nx = S_REQ;
                end
            end
            default: w_state_nx = S_REQ;
        endcase
    end
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_stale     <= '0;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
            r_valid     <= 1'b0;
            r_out_pc    <= '0;
            r_instr     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_stale     <= w_stale_nx;
            r_skid_pc   <= w_skid_pc_nx;
            r_skid_data <= w_skid_data_nx;
            if (bus.in_redirect) begin
                r_valid <= 1'b0;
                r_instr <= '0;
            end else if (!bus.in_stall) begin
                r_valid  <= w_load;
                r_instr  <= w_load ? w_ld_data : '0;
                r_out_pc <= w_load ? w_ld_pc : r_out_pc;
            end
        end
    end
    assign bus.out_imem_req  = w_req;
    assign bus.out_imem_addr = r_state == S_DROP ? r_stale : r_pc;
    assign bus.out_valid     = r_valid;
    assign bus.out_pc        = r_out_pc;
    assign bus.out_instr     = r_instr;
    assign bus.out_opcode    = r_instr[DATA_W-1 -: 4];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage; imem returns data equal to the address.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst, rst_w;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    fetch_stage_if #(.DATA_W(32)) bus ();
    fetch_stage_if #(.DATA_W(32)) wbus ();
    fetch_stage #(.RESET_PC(32'h0000_0010), .DATA_W(32)) u_dut (
        .in_clk(clk), .in_rst(rst), .bus(bus.master)
    );
    fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .DATA_W(32)) u_wrap (
        .in_clk(clk), .in_rst(rst_w), .bus(wbus.master)
    );
    assign bus.in_imem_data  = bus.out_imem_addr;
    assign wbus.in_imem_data = wbus.out_imem_addr;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic set(input logic st, input logic rd, input logic [31:0] rpc, input logic ack);
        bus.in_stall       = st;
        bus.in_redirect    = rd;
        bus.in_redirect_pc = rpc;
        bus.in_imem_ack    = ack;
    endtask
    initial begin
        rst = 1'b1;
        rst_w = 1'b1;
        set(1'b0, 1'b0, 32'h0, 1'b1);
        wbus.in_stall = 1'b0;
        wbus.in_redirect = 1'b0;
        wbus.in_redirect_pc = 32'h0;
        wbus.in_imem_ack = 1'b1;
        cyc();
        cyc();
        chk("rst_req", bus.out_imem_req, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_instr", bus.out_instr, 0);
        chk("rst_opcode", bus.out_opcode, 0);
        rst = 1'b0;
        #1;
        chk("first_req", bus.out_imem_req, 1);
        chk("first_addr", bus.out_imem_addr, 32'h10);
        chk("first_valid", bus.out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("zw_valid", bus.out_valid, 1);
            chk("zw_pc", bus.out_pc, 32'h10 + i);
            chk("zw_instr", bus.out_instr, 32'h10 + i);
        end
        // wait states: ack on every third cycle
        for (int k = 0; k < 6; k++) begin
            bus.in_imem_ack = (k % 3 == 2);
            cyc();
            chk("ws_valid", bus.out_valid, (k % 3 == 2) ? 1 : 0);
            chk("ws_instr", bus.out_instr, (k % 3 == 2) ? 32'h13 + k / 3 : 0);
            chk("ws_pc", bus.out_pc, 32'h12 + (k + 1) / 3);
            chk("ws_addr", bus.out_imem_addr, 32'h13 + (k + 1) / 3);
        end
        set(1'b0, 1'b1, 32'h1F, 1'b1);
        cyc();
        chk("rd1f_valid", bus.out_valid, 0);
        chk("rd1f_addr", bus.out_imem_addr, 32'h1F);
        set(1'b0, 1'b0, 32'h0, 1'b1);
        cyc();
        chk("ld1f_instr", bus.out_instr, 32'h1F);
        chk("ld1f_addr", bus.out_imem_addr, 32'h20);
        set(1'b1, 1'b0, 32'h0, 1'b1);
        cyc();
        chk("stall_instr", bus.out_instr, 32'h1F);
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_req", bus.out_imem_req, 0);
        cyc();
        chk("stall2_pc", bus.out_pc, 32'h1F);
        chk("stall2_req", bus.out_imem_req, 0);
        set(1'b0, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("skid_instr", bus.out_instr, 32'h20);
        chk("skid_pc", bus.out_pc, 32'h20);
        chk("skid_valid", bus.out_valid, 1);
        chk("skid_req", bus.out_imem_req, 1);
        chk("skid_addr", bus.out_imem_addr, 32'h21);
        set(1'b0, 1'b0, 32'h0, 1'b1);
        cyc();
        chk("post_skid_instr", bus.out_instr, 32'h21);
        set(1'b0, 1'b1, 32'h05, 1'b1);
        cyc();
        chk("rd05_addr", bus.out_imem_addr, 32'h05);
        set(1'b0, 1'b1, 32'h80, 1'b0);
        cyc();
        chk("drop_addr", bus.out_imem_addr, 32'h05);
        chk("drop_req", bus.out_imem_req, 1);
        chk("drop_valid", bus.out_valid, 0);
        set(1'b0, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("drop_wait_addr", bus.out_imem_addr, 32'h05);
        chk("drop_wait_valid", bus.out_valid, 0);
        set(1'b0, 1'b0, 32'h0, 1'b1);
        cyc();
        chk("drop_ack_addr", bus.out_imem_addr, 32'h80);
        chk("drop_ack_valid", bus.out_valid, 0);
        chk("drop_ack_instr", bus.out_instr, 0);
        cyc();
        chk("tgt_instr", bus.out_instr, 32'h80);
        chk("tgt_pc", bus.out_pc, 32'h80);
        chk("tgt_valid", bus.out_valid, 1);
        set(1'b1, 1'b0, 32'h0, 1'b1);
        cyc();
        chk("full_req", bus.out_imem_req, 0);
        chk("full_instr", bus.out_instr, 32'h80);
        set(1'b1, 1'b1, 32'hA000_0040, 1'b1);
        cyc();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_instr", bus.out_instr, 0);
        chk("flush_opcode", bus.out_opcode, 0);
        chk("flush_req", bus.out_imem_req, 1);
        chk("flush_addr", bus.out_imem_addr, 32'hA000_0040);
        set(1'b0, 1'b0, 32'h0, 1'b1);
        cyc();
        chk("flush_ld_instr", bus.out_instr, 32'hA000_0040);
        chk("flush_ld_opcode", bus.out_opcode, 32'hA);
        chk("flush_ld_valid", bus.out_valid, 1);
        rst_w = 1'b0;
        cyc();
        chk("wrap_pc0", wbus.out_pc, 32'hFFFF_FFFF);
        chk("wrap_op0", wbus.out_opcode, 32'hF);
        cyc();
        chk("wrap_pc1", wbus.out_pc, 32'h0);
        chk("wrap_op1", wbus.out_opcode, 32'h0);
        cyc();
        chk("wrap_pc2", wbus.out_pc, 32'h1);
        chk("wrap_addr", wbus.out_imem_addr, 32'h2);
        wbus.in_imem_ack = 1'b0;
        wbus.in_redirect = 1'b1;
        wbus.in_redirect_pc = 32'h55;
        cyc();
        chk("wdrop_addr", wbus.out_imem_addr, 32'h2);
        chk("wdrop_req", wbus.out_imem_req, 1);
        wbus.in_redirect = 1'b0;
        wbus.in_imem_ack = 1'b1;
        rst_w = 1'b1;
        #1;
        chk("wrst_req", wbus.out_imem_req, 0);
        cyc();
        chk("wrst_valid", wbus.out_valid, 0);
        chk("wrst_pc", wbus.out_pc, 0);
        chk("wrst_instr", wbus.out_instr, 0);
        rst_w = 1'b0;
        wbus.in_imem_ack = 1'b0;
        #1;
        chk("wrel_req", wbus.out_imem_req, 1);
        chk("wrel_addr", wbus.out_imem_addr, 32'hFFFF_FFFF);
        wbus.in_imem_ack = 1'b1;
        cyc();
        chk("wrel_pc", wbus.out_pc, 32'hFFFF_FFFF);
        chk("wrel_valid", wbus.out_valid, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
